// File: rtl/rv32_spi_pkg.sv
// Shared register offsets, bit positions and engine state type for the
// wishbone SPI master.
package rv32_spi_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CLKDIV = 2'd3;

  localparam int CTRL_CS_BIT   = 0;
  localparam int CTRL_CPOL_BIT = 1;
  localparam int CTRL_CPHA_BIT = 2;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_RXV_BIT  = 1;
  localparam int STAT_OVR_BIT  = 2;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } spi_state_t;

endpackage

// File: rtl/spi_shift_engine.sv
// MSB-first 8-bit full-duplex SPI shift engine: divider, bit counter and
// shift registers; mode bits are latched when a transfer starts.
module spi_shift_engine
  import rv32_spi_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       tx_byte,
  input  logic [DIV_W-1:0] div,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             miso,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rx_byte,
  output logic             sck,
  output logic             mosi,
  output spi_state_t       state
);

  spi_state_t       state_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_sr;
  logic [7:0]       rx_sr;
  logic             sck_q;
  logic             cpol_q;
  logic             cpha_q;
  logic             leading;

  // Leading edge = sck moving away from its idle level.
  assign leading = (sck_q == cpol_q);
  assign sck     = (state_q == IDLE) ? cpol : sck_q;
  assign done    = (state_q == DONE);
  assign state   = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      cnt     <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      sck_q   <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      rx_byte <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SHIFT;
            div_q   <= div;
            cnt     <= '0;
            bit_cnt <= '0;
            tx_sr   <= tx_byte;
            rx_sr   <= '0;
            sck_q   <= cpol;
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            mosi    <= cpha ? 1'b0 : tx_byte[7];
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt != div_q) begin
            cnt <= cnt + DIV_W'(1);
          end else begin
            cnt   <= '0;
            sck_q <= ~sck_q;
            // CPHA swaps which edge samples and which edge shifts.
            if (leading ^ cpha_q) begin
              rx_sr <= {rx_sr[6:0], miso};
            end else begin
              mosi  <= cpha_q ? tx_sr[7] : tx_sr[6];
              tx_sr <= {tx_sr[6:0], 1'b0};
            end
            if (!leading) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state_q <= DONE;
            end
          end
        end
        DONE: begin
          rx_byte <= rx_sr;
          busy    <= 1'b0;
          mosi    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/wishbone_spi_controller.sv
// Wishbone-classic slave SPI master: register decode, ack and status around
// spi_shift_engine. Define SPI_MODE_SEL_EN to make CTRL CPOL/CPHA writable.
module wishbone_spi_controller
  import rv32_spi_pkg::*;
#(
  parameter int CLK_DIV_RESET = 4,
  parameter int DIV_W         = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  input  logic        spi_miso_i,
  output logic        spi_mosi_o,
  output logic        spi_sck_o,
  output logic        spi_cs_o
);

  logic             req;
  logic             wr_en;
  logic             wr_data;
  logic             start;
  logic             cs_assert;
  logic             cpol;
  logic             cpha;
  logic             rx_valid;
  logic             overrun;
  logic [DIV_W-1:0] clkdiv;
  logic [DIV_W-1:0] div_wr;
  logic [31:0]      rd_data;
  logic             eng_busy;
  logic             eng_done;
  logic [7:0]       rx_byte;
  spi_state_t       eng_state;
  logic             unused_bits;

  // Every side effect commits on the edge that raises ack.
  assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_en   = req & wb_we_i;
  assign wr_data = wr_en & (wb_adr_i == REG_DATA) & wb_sel_i[0];
  assign start   = wr_data & (eng_state == IDLE);
  assign spi_cs_o = ~cs_assert;
  assign unused_bits = ^{wb_dat_i, wb_sel_i};

  always_comb begin
    div_wr = clkdiv;
    for (int i = 0; i < DIV_W; i++) begin
      div_wr[i] = wb_sel_i[i / 8] ? wb_dat_i[i] : clkdiv[i];
    end
  end

  always_comb begin
    rd_data = '0;
    case (wb_adr_i)
      REG_DATA: rd_data[7:0] = rx_byte;
      REG_CTRL: begin
        rd_data[CTRL_CS_BIT]   = cs_assert;
        rd_data[CTRL_CPOL_BIT] = cpol;
        rd_data[CTRL_CPHA_BIT] = cpha;
      end
      REG_STATUS: begin
        rd_data[STAT_BUSY_BIT] = eng_busy;
        rd_data[STAT_RXV_BIT]  = rx_valid;
        rd_data[STAT_OVR_BIT]  = overrun;
      end
      default: rd_data[DIV_W-1:0] = clkdiv;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      cs_assert <= 1'b0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      clkdiv    <= DIV_W'(CLK_DIV_RESET);
    end else begin
      wb_ack_o <= req;
      if (req && !wb_we_i) wb_dat_o <= rd_data;
      if (wr_en && wb_sel_i[0] && (wb_adr_i == REG_CTRL))
        cs_assert <= wb_dat_i[CTRL_CS_BIT];
      if (wr_data && !start)
        overrun <= 1'b1;
      else if (wr_en && wb_sel_i[0] && (wb_adr_i == REG_STATUS) && wb_dat_i[STAT_OVR_BIT])
        overrun <= 1'b0;
      // A fresh byte wins over a read-clear landing on the same edge.
      if (eng_done)
        rx_valid <= 1'b1;
      else if (req && !wb_we_i && (wb_adr_i == REG_DATA))
        rx_valid <= 1'b0;
      if (wr_en && (wb_adr_i == REG_CLKDIV)) clkdiv <= div_wr;
    end
  end

`ifdef SPI_MODE_SEL_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cpol <= 1'b0;
      cpha <= 1'b0;
    end else if (wr_en && wb_sel_i[0] && (wb_adr_i == REG_CTRL)) begin
      cpol <= wb_dat_i[CTRL_CPOL_BIT];
      cpha <= wb_dat_i[CTRL_CPHA_BIT];
    end
  end
`else
  assign cpol = 1'b0;
  assign cpha = 1'b0;
`endif

  spi_shift_engine #(
    .DIV_W(DIV_W)
  ) u_engine (
    .clk     (clk_i),
    .rst     (rst_i),
    .start   (start),
    .tx_byte (wb_dat_i[7:0]),
    .div     (clkdiv),
    .cpol    (cpol),
    .cpha    (cpha),
    .miso    (spi_miso_i),
    .busy    (eng_busy),
    .done    (eng_done),
    .rx_byte (rx_byte),
    .sck     (spi_sck_o),
    .mosi    (spi_mosi_o),
    .state   (eng_state)
  );

endmodule

// File: tb/tb_wishbone_spi_controller.sv
// Directed bench for wishbone_spi_controller: register access, handshake,
// transfers, overrun and reset-abort behaviour.
module tb_wishbone_spi_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  adr = '0;
  logic [31:0] dat_w = '0;
  logic        we = 1'b0;
  logic        stb = 1'b0;
  logic [3:0]  sel = '0;
  logic        cyc = 1'b0;
  logic        ack;
  logic [31:0] dat_r;
  logic        miso;
  logic        mosi;
  logic        sck;
  logic        cs;
  logic        loop_en = 1'b0;
  logic        miso_drv = 1'b0;

  int total = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;
  assign miso = loop_en ? mosi : miso_drv;

  wishbone_spi_controller #(
    .CLK_DIV_RESET(4),
    .DIV_W(16)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .wb_adr_i  (adr),
    .wb_dat_i  (dat_w),
    .wb_we_i   (we),
    .wb_stb_i  (stb),
    .wb_sel_i  (sel),
    .wb_cyc_i  (cyc),
    .wb_ack_o  (ack),
    .wb_dat_o  (dat_r),
    .spi_miso_i(miso),
    .spi_mosi_o(mosi),
    .spi_sck_o (sck),
    .spi_cs_o  (cs)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic [1:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rdata);
    int n;
    cyc = 1'b1; stb = 1'b1; adr = a; we = w; dat_w = d; sel = s;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 8);
    check("ack_seen", {31'b0, ack}, 32'd1);
    rdata = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    wb_xfer(a, 1'b1, d, s, dummy);
  endtask

  task automatic wb_read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(a, 1'b0, 32'h0, 4'hF, rd);
    check(tag, rd, exp);
  endtask

  // Samples 40 cycles after a transfer start; miso advances after each rising sck.
  task automatic capture(input logic [7:0] pat, input int first_rise,
                         output logic [7:0] mosi_byte, output int rises,
                         output int bad_rise, output int busy_cycles);
    logic prev;
    int k;
    mosi_byte = '0; rises = 0; bad_rise = 0; busy_cycles = 0; k = 0;
    miso_drv = pat[7];
    prev = sck;
    if (dut.eng_busy) busy_cycles++;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (dut.eng_busy) busy_cycles++;
      if (sck && !prev) begin
        if (i != first_rise + 4 * rises) bad_rise++;
        mosi_byte = {mosi_byte[6:0], mosi};
        rises++;
        k++;
        if (k < 8) miso_drv = pat[7 - k];
      end
      prev = sck;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  acks;
    logic [31:0] hs_dat;
    logic [7:0]  mb;
    int          rises, bad, busy_n, n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_dat", dat_r, 32'd0);
    check("rst_sck", {31'b0, sck}, 32'd0);
    check("rst_mosi", {31'b0, mosi}, 32'd0);
    check("rst_cs", {31'b0, cs}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Handshake: cyc/stb held 6 cycles on a CLKDIV read
    adr = 2'd3; we = 1'b0; sel = 4'h0; cyc = 1'b1; stb = 1'b1;
    acks = '0; hs_dat = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      acks[i] = ack;
      if (ack) hs_dat = dat_r;
    end
    cyc = 1'b0; stb = 1'b0;
    check("hs_ack_pattern", {26'b0, acks}, 32'h15);
    check("hs_clkdiv_reset", hs_dat, 32'd4);

    // sel=0 writes change nothing
    wb_write(2'd3, 32'h0000_FFFF, 4'h0);
    wb_read_check("sel0_clkdiv", 2'd3, 32'd4);
    wb_write(2'd1, 32'h1, 4'h0);
    check("sel0_cs", {31'b0, cs}, 32'd1);
    wb_write(2'd0, 32'hFF, 4'h0);
    wb_read_check("sel0_status", 2'd2, 32'd0);

    // CLKDIV byte lanes
    wb_write(2'd3, 32'h0000_1203, 4'b0001);
    wb_read_check("lane0_clkdiv", 2'd3, 32'h0003);
    wb_write(2'd3, 32'h0000_0700, 4'b0010);
    wb_read_check("lane1_clkdiv", 2'd3, 32'h0703);

    // Reset mid-transfer
    wb_write(2'd1, 32'h1, 4'hF);
    check("cs_asserted", {31'b0, cs}, 32'd0);
    wb_write(2'd3, 32'd3, 4'hF);
    wb_write(2'd0, 32'hA5, 4'hF);
    wb_read_check("mid_status_busy", 2'd2, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("mid_sck_high", {31'b0, sck}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_sck", {31'b0, sck}, 32'd0);
    check("arst_cs", {31'b0, cs}, 32'd1);
    check("arst_ack", {31'b0, ack}, 32'd0);
    check("arst_mosi", {31'b0, mosi}, 32'd0);
    check("arst_busy", {31'b0, dut.eng_busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    wb_read_check("arst_status", 2'd2, 32'd0);
    wb_read_check("arst_clkdiv", 2'd3, 32'd4);
    wb_read_check("arst_data", 2'd0, 32'd0);

    // Basic transfer, loopback, div=1
    wb_write(2'd1, 32'h1, 4'hF);
    check("basic_cs", {31'b0, cs}, 32'd0);
    wb_write(2'd3, 32'd1, 4'hF);
    loop_en = 1'b1;
    wb_write(2'd0, 32'hA5, 4'hF);
    capture(8'h00, 2, mb, rises, bad, busy_n);
    check("basic_mosi_bits", {24'b0, mb}, 32'hA5);
    check("basic_rises", rises, 32'd8);
    check("basic_period", bad, 32'd0);
    check("basic_busy_cycles", busy_n, 32'd33);
    check("basic_mosi_idle", {31'b0, mosi}, 32'd0);
    wb_read_check("basic_status_rxv", 2'd2, 32'd2);
    wb_read_check("basic_data", 2'd0, 32'hA5);
    wb_read_check("basic_status_clr", 2'd2, 32'd0);

    // MISO pattern while sending 0xFF
    loop_en = 1'b0;
    wb_write(2'd0, 32'hFF, 4'hF);
    capture(8'h3C, 2, mb, rises, bad, busy_n);
    check("miso_mosi_bits", {24'b0, mb}, 32'hFF);
    wb_read_check("miso_status", 2'd2, 32'd2);
    wb_read_check("miso_data", 2'd0, 32'h3C);

    // Write while busy
    loop_en = 1'b1;
    wb_write(2'd0, 32'h5A, 4'hF);
    wb_write(2'd0, 32'h11, 4'hF);
    wb_read_check("ovr_status", 2'd2, 32'd5);
    wb_write(2'd2, 32'h4, 4'hF);
    wb_read_check("ovr_cleared", 2'd2, 32'd1);
    n = 0;
    while (dut.eng_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("ovr_done", {31'b0, dut.eng_busy}, 32'd0);
    wb_read_check("ovr_status_end", 2'd2, 32'd2);
    wb_read_check("ovr_data", 2'd0, 32'h5A);

`ifdef SPI_MODE_SEL_EN
    // Mode 3
    loop_en = 1'b0;
    wb_write(2'd1, 32'h7, 4'hF);
    check("m3_idle_sck", {31'b0, sck}, 32'd1);
    wb_read_check("m3_ctrl", 2'd1, 32'h7);
    wb_write(2'd0, 32'h80, 4'hF);
    check("m3_mosi_start", {31'b0, mosi}, 32'd0);
    capture(8'h96, 4, mb, rises, bad, busy_n);
    check("m3_mosi_bits", {24'b0, mb}, 32'h80);
    check("m3_rises", rises, 32'd8);
    check("m3_period", bad, 32'd0);
    check("m3_busy_cycles", busy_n, 32'd33);
    check("m3_sck_end", {31'b0, sck}, 32'd1);
    wb_read_check("m3_data", 2'd0, 32'h96);
`else
    wb_write(2'd1, 32'h7, 4'hF);
    wb_read_check("ctrl_mode_bits", 2'd1, 32'h1);
    check("ctrl_sck_idle", {31'b0, sck}, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
